// File: rtl/operand_forward_stage.sv
// Execute-stage operand forwarding mux.
// Keeps a 2-deep EX result history and stalls on outstanding loads.
module operand_forward_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             rs1_sel,
  input  logic [1:0]             rs2_sel,
  input  logic [XLEN-1:0]        rf_rs1,
  input  logic [XLEN-1:0]        rf_rs2,
  input  logic                   ex_valid,
  input  logic                   ex_is_load,
  input  logic [XLEN-1:0]        ex_result,
  input  logic                   mem_load_valid,
  input  logic [XLEN-1:0]        mem_load_data,
  output logic [XLEN-1:0]        op1,
  output logic [XLEN-1:0]        op2,
  output logic                   fwd_stall,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            pend;
  } hist_t;

  typedef enum logic {RUN, WAIT} state_t;

  state_t state;
  hist_t  h0, h1;
  hist_t  f0, f1;
  logic   fill0, fill1;
  logic [XLEN-1:0] v1, v2;
  logic   r1, r2;
  logic   stall;

  // Apply same-cycle load fill to the oldest pending entry
  always_comb begin
    fill1 = mem_load_valid & h1.pend;
    fill0 = mem_load_valid & ~h1.pend & h0.pend;
    f0 = h0;
    f1 = h1;
    if (fill0) f0 = '{data: mem_load_data, pend: 1'b0};
    if (fill1) f1 = '{data: mem_load_data, pend: 1'b0};
  end

  // Resolve each operand against the post-fill history
  always_comb begin
    v1 = rf_rs1;
    r1 = 1'b1;
    unique case (1'b1)
      (rs1_sel == 2'b10): begin
        v1 = f1.data;
        r1 = ~f1.pend;
      end
      (rs1_sel[0]): begin
        v1 = f0.data;
        r1 = ~f0.pend;
      end
      default: ;
    endcase
    v2 = rf_rs2;
    r2 = 1'b1;
    unique case (1'b1)
      (rs2_sel == 2'b10): begin
        v2 = f1.data;
        r2 = ~f1.pend;
      end
      (rs2_sel[0]): begin
        v2 = f0.data;
        r2 = ~f0.pend;
      end
      default: ;
    endcase
    stall = ~(r1 & r2);
  end

  assign fwd_stall = stall;

  // FSM, history update, operand capture and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      h0           <= '0;
      h1           <= '0;
      op1          <= '0;
      op2          <= '0;
      stall_cycles <= '0;
    end else begin
      if (stall && !(&stall_cycles))
        stall_cycles <= stall_cycles + 1'b1;
      unique case (state)
        RUN: begin
          if (stall) begin
            state <= WAIT;
            h0    <= f0;
            h1    <= f1;
          end else begin
            op1 <= v1;
            op2 <= v2;
            if (ex_valid) begin
              h1 <= f0;
              h0 <= '{data: ex_result, pend: ex_is_load};
            end else begin
              h0 <= f0;
              h1 <= f1;
            end
          end
        end
        WAIT: begin
          if (stall) begin
            h0 <= f0;
            h1 <= f1;
          end else begin
            state <= RUN;
            op1   <= v1;
            op2   <= v2;
            if (ex_valid) begin
              h1 <= f0;
              h0 <= '{data: ex_result, pend: ex_is_load};
            end else begin
              h0 <= f0;
              h1 <= f1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_forward_stage.sv
// Directed bench for operand_forward_stage.
// Each task drives one scenario and checks inline.
module tb_operand_forward_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rs1_sel, rs2_sel;
  logic [31:0] rf_rs1, rf_rs2;
  logic        ex_valid, ex_is_load;
  logic [31:0] ex_result;
  logic        mem_load_valid;
  logic [31:0] mem_load_data;
  logic [31:0] op1, op2;
  logic        fwd_stall;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  operand_forward_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .rs1_sel(rs1_sel),
    .rs2_sel(rs2_sel),
    .rf_rs1(rf_rs1),
    .rf_rs2(rf_rs2),
    .ex_valid(ex_valid),
    .ex_is_load(ex_is_load),
    .ex_result(ex_result),
    .mem_load_valid(mem_load_valid),
    .mem_load_data(mem_load_data),
    .op1(op1),
    .op2(op2),
    .fwd_stall(fwd_stall),
    .stall_cycles(stall_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_sel = 2'b00;
    rs2_sel = 2'b00;
    rf_rs1 = '0;
    rf_rs2 = '0;
    ex_valid = 1'b0;
    ex_is_load = 1'b0;
    ex_result = '0;
    mem_load_valid = 1'b0;
    mem_load_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic push(input logic ld, input logic [31:0] r);
    ex_valid = 1'b1;
    ex_is_load = ld;
    ex_result = r;
    tick();
    ex_valid = 1'b0;
    ex_is_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (op1 !== 32'h0 || op2 !== 32'h0) begin
      bad++;
      $display("FAIL reset_ops got %h %h want 0 0", op1, op2);
    end
    total++;
    if (fwd_stall !== 1'b0 || stall_cycles !== 16'd0) begin
      bad++;
      $display("FAIL reset_stall got %b %0d want 0 0",
               fwd_stall, stall_cycles);
    end
  endtask

  task automatic test_rf();
    rf_rs1 = 32'h11;
    rf_rs2 = 32'h22;
    #1;
    total++;
    if (fwd_stall !== 1'b0) begin
      bad++;
      $display("FAIL rf_stall got %b want 0", fwd_stall);
    end
    tick();
    total++;
    if (op1 !== 32'h11 || op2 !== 32'h22) begin
      bad++;
      $display("FAIL rf_ops got %h %h want 11 22", op1, op2);
    end
    idle();
  endtask

  task automatic test_hist();
    push(1'b0, 32'hA);
    push(1'b0, 32'hB);
    rs1_sel = 2'b01;
    rs2_sel = 2'b10;
    #1;
    total++;
    if (fwd_stall !== 1'b0) begin
      bad++;
      $display("FAIL hist_stall got %b want 0", fwd_stall);
    end
    tick();
    total++;
    if (op1 !== 32'hB || op2 !== 32'hA) begin
      bad++;
      $display("FAIL hist_ops got %h %h want b a", op1, op2);
    end
    rs1_sel = 2'b11;
    rs2_sel = 2'b00;
    rf_rs2 = 32'h33;
    tick();
    tick();
    total++;
    if (op1 !== 32'hB || op2 !== 32'h33) begin
      bad++;
      $display("FAIL hist_sel11 got %h %h want b 33", op1, op2);
    end
    idle();
  endtask

  task automatic test_load_stall();
    do_reset();
    push(1'b1, 32'h99);
    rs1_sel = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (fwd_stall !== 1'b1) begin
        bad++;
        $display("FAIL ld_stall%0d got %b want 1", i, fwd_stall);
      end
      tick();
    end
    total++;
    if (op1 !== 32'h0) begin
      bad++;
      $display("FAIL ld_hold got %h want 0", op1);
    end
    mem_load_valid = 1'b1;
    mem_load_data = 32'h55;
    #1;
    total++;
    if (fwd_stall !== 1'b0) begin
      bad++;
      $display("FAIL ld_release got %b want 0", fwd_stall);
    end
    tick();
    mem_load_valid = 1'b0;
    total++;
    if (op1 !== 32'h55 || stall_cycles !== 16'd3) begin
      bad++;
      $display("FAIL ld_result got %h %0d want 55 3",
               op1, stall_cycles);
    end
    idle();
  endtask

  task automatic test_bypass();
    do_reset();
    push(1'b1, 32'h90);
    rs1_sel = 2'b01;
    mem_load_valid = 1'b1;
    mem_load_data = 32'h77;
    #1;
    total++;
    if (fwd_stall !== 1'b0) begin
      bad++;
      $display("FAIL byp_stall got %b want 0", fwd_stall);
    end
    tick();
    mem_load_valid = 1'b0;
    total++;
    if (op1 !== 32'h77 || stall_cycles !== 16'd0) begin
      bad++;
      $display("FAIL byp_result got %h %0d want 77 0",
               op1, stall_cycles);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(1'b1, 32'hA0);
    push(1'b1, 32'hB0);
    rs1_sel = 2'b01;
    rs2_sel = 2'b10;
    #1;
    total++;
    if (fwd_stall !== 1'b1) begin
      bad++;
      $display("FAIL b2b_stall0 got %b want 1", fwd_stall);
    end
    tick();
    mem_load_valid = 1'b1;
    mem_load_data = 32'h1;
    #1;
    total++;
    if (fwd_stall !== 1'b1) begin
      bad++;
      $display("FAIL b2b_stall1 got %b want 1", fwd_stall);
    end
    tick();
    mem_load_data = 32'h2;
    #1;
    total++;
    if (fwd_stall !== 1'b0) begin
      bad++;
      $display("FAIL b2b_release got %b want 0", fwd_stall);
    end
    tick();
    mem_load_valid = 1'b0;
    total++;
    if (op1 !== 32'h2 || op2 !== 32'h1) begin
      bad++;
      $display("FAIL b2b_ops got %h %h want 2 1", op1, op2);
    end
    total++;
    if (stall_cycles !== 16'd2) begin
      bad++;
      $display("FAIL b2b_count got %0d want 2", stall_cycles);
    end
    idle();
  endtask

  task automatic test_reset_mid_wait();
    push(1'b1, 32'hC0);
    rs1_sel = 2'b01;
    #1;
    total++;
    if (fwd_stall !== 1'b1) begin
      bad++;
      $display("FAIL rmw_stall got %b want 1", fwd_stall);
    end
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (fwd_stall !== 1'b0 || op1 !== 32'h0 || op2 !== 32'h0) begin
      bad++;
      $display("FAIL rmw_async got %b %h %h want 0 0 0",
               fwd_stall, op1, op2);
    end
    tick();
    rst_n = 1'b1;
    mem_load_valid = 1'b1;
    mem_load_data = 32'hEE;
    #1;
    total++;
    if (fwd_stall !== 1'b0) begin
      bad++;
      $display("FAIL rmw_stale_stall got %b want 0", fwd_stall);
    end
    tick();
    mem_load_valid = 1'b0;
    tick();
    total++;
    if (op1 !== 32'h0 || stall_cycles !== 16'd0) begin
      bad++;
      $display("FAIL rmw_stale got %h %0d want 0 0",
               op1, stall_cycles);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    test_reset();
    test_rf();
    test_hist();
    test_load_stall();
    test_bypass();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
